sram_mem_initiator: RTL and testbench
=====================================

Name: sram_mem_initiator

Overview:
- MEM-stage master that issues the pipeline's load/store requests to a 16-bit off-chip SRAM.
- Each 32-bit word access is split into two half-word SRAM cycles, each with programmable wait states.
- Drives ready low to freeze the pipeline until the access completes, then returns the assembled load word.
- Sits between the EXE/MEM pipeline register and the SRAM pins.

Parameters:
- ADDR_W, 32, width of the pipeline address (ALU result).
- DATA_W, 32, width of the pipeline data word.
- SRAM_ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 5, cycles per half-word phase (legal values >= 1).
- BASE_ADDR, 1024, byte address that maps to SRAM half-word 0.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- rd_en  input  1  load request from the MEM stage
- wr_en  input  1  store request from the MEM stage
- address  input  ADDR_W  byte address (ALU result)
- wdata  input  DATA_W  store data (Rm value)
- rdata  output  DATA_W  last completed load word
- ready  output  1  high when the pipeline may advance
- sram_addr  output  SRAM_ADDR_W  SRAM half-word address
- sram_dq_out  output  16  write data toward the SRAM
- sram_dq_oe  output  1  data-bus drive enable
- sram_dq_in  input  16  read data from the SRAM
- sram_ce_n  output  1  chip enable, active low
- sram_oe_n  output  1  output enable, active low
- sram_we_n  output  1  write enable, active low

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clk is the clock. All registers use posedge clk / posedge rst.
- Reset values: state=IDLE, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
- Reset mid-access aborts immediately and deasserts all strobes; nothing is retried.
- Request and ready:
  - req = rd_en | wr_en.
  - ready = ~req | (state==DONE), combinational.
  - The pipeline holds address, wdata and the enables stable while ready=0.
- Request capture, on leaving IDLE:
  - Latches address, wdata and kind.
  - kind = write if wr_en, else read. Write wins if both enables are set; rdata is unchanged in that case.
  - Dropping req mid-access does not cancel it: the access completes and a one-cycle DONE still occurs.
- Address mapping:
  - off = latched address - BASE_ADDR, ADDR_W-bit wrap-around subtraction.
  - Half-word index hw = {off[SRAM_ADDR_W:2], 1'b0}.
  - The LOW phase uses hw, the HIGH phase uses hw+1.
  - address[1:0] is ignored (word aligned).
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter cnt counts 0..WAIT_CYCLES-1.
  - IDLE: if req, go to LOW with cnt=0.
  - LOW: after WAIT_CYCLES cycles, go to HIGH with cnt=0.
  - HIGH: after WAIT_CYCLES cycles, go to DONE.
  - DONE: go to IDLE unconditionally. The next instruction's request is seen in IDLE on the following cycle.
- Latency: request first seen in IDLE at cycle 0 → ready=1 in cycle 2*WAIT_CYCLES+1. With defaults this is cycle 11; the stall is 11 cycles.
- Pins during LOW/HIGH:
  - sram_ce_n=0; sram_addr = phase address.
  - Read: sram_oe_n=0, sram_dq_oe=0.
  - Write: sram_dq_oe=1, sram_dq_out = wdata[15:0] in LOW and wdata[31:16] in HIGH.
  - Write strobe: sram_we_n=0 for cnt < WAIT_CYCLES-1 and 1 on the last cycle of each phase, so data is held past the rising edge of we_n.
- Read capture: on the edge ending the last LOW cycle, sram_dq_in goes to the low half of a holding register. On the edge ending the last HIGH cycle, rdata = {sram_dq_in, low half}.
- rdata is stable from DONE until the next read completes.
- All strobes are inactive in IDLE and DONE.

Optional Feature:
- Macro: SRAM_RANGE_CHECK_EN.
- Defined: a request with address < BASE_ADDR, or with off >= 2^(SRAM_ADDR_W+1), goes IDLE→DONE directly with no SRAM cycle and ready in cycle 1.
  - An out-of-range write is dropped.
  - An out-of-range read sets rdata=0.
- Not defined: no check; the address wraps modulo the SRAM size as in the address mapping above.

Test Plan:
- Store then load: wr_en, address=1024, wdata=0xDEADBEEF.
  - Write phases: sram_addr=0 carries 0xBEEF, sram_addr=1 carries 0xDEAD; ready=1 in cycle 11.
  - Then rd_en at 1024 with the SRAM model returning the same values: rdata=0xDEADBEEF.
- Address mapping: address=1037, read → sram_addr 6 then 7; misaligned low bits are ignored.
- Simultaneous rd_en=wr_en=1, address=1028, wdata=0x12345678 → write cycles on 2/3; rdata holds its previous value; sram_oe_n stays 1.
- Back-to-back requests: req held constant across DONE → one ready pulse per access; second access starts the cycle after DONE; no idle-cycle SRAM strobes.
- Reset mid-access: assert rst in HIGH cycle 2 → all strobes inactive within the same cycle; state=IDLE; rdata=0.
- Range check: SRAM_RANGE_CHECK_EN defined, read at address=512 → ready in cycle 1, rdata=0, sram_ce_n stays 1. Macro undefined, same read → normal 11-cycle access at the wrapped address.

Source files
------------

// File: rtl/sram_mem_initiator_if.sv
// Pipeline-side request/response signals plus the 16-bit SRAM pin bundle.
// master: the initiator itself. slave: the environment (pipeline + SRAM).
interface sram_mem_initiator_if #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SRAM_ADDR_W = 18
);
  logic                   rd_en;
  logic                   wr_en;
  logic [ADDR_W-1:0]      address;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W-1:0]      rdata;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic                   sram_dq_oe;
  logic [15:0]            sram_dq_in;
  logic                   sram_ce_n;
  logic                   sram_oe_n;
  logic                   sram_we_n;

  modport master (
    input  rd_en, wr_en, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n
  );

  modport slave (
    output rd_en, wr_en, address, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_mem_initiator.sv
// MEM-stage master: each 32-bit load/store becomes two 16-bit SRAM phases
// (low half-word, then high half-word), each WAIT_CYCLES long. ready is held
// low until the access reaches DONE.
// Optional build macro: SRAM_RANGE_CHECK_EN -- requests outside the SRAM
// window skip the SRAM entirely (write dropped, read returns 0).
//
// state | meaning
// IDLE  | no access; a request here is captured and started
// LOW   | low half-word phase at word's even half-word address
// HIGH  | high half-word phase at the odd half-word address
// DONE  | one-cycle completion; ready=1, rdata valid
module sram_mem_initiator #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                SRAM_ADDR_W = 18,
  parameter int                WAIT_CYCLES = 5,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 1024
) (
  input logic                  clk,
  input logic                  rst,
  sram_mem_initiator_if.master bus_if
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   is_wr_q;
  logic [15:0]            lo_q;
  logic [DATA_W-1:0]      rdata_q;

  logic                   req;
  logic                   last;
  logic                   out_of_range;
  logic [ADDR_W-1:0]      off;
  logic                   ce_n, oe_n, we_n, dq_oe;
  logic [15:0]            dq_out;
  logic [SRAM_ADDR_W-1:0] phase_addr;

  assign req  = bus_if.rd_en | bus_if.wr_en;
  assign last = (cnt_q == CNT_LAST);
  assign off  = bus_if.address - BASE_ADDR;

`ifdef SRAM_RANGE_CHECK_EN
  assign out_of_range = (bus_if.address < BASE_ADDR) ||
                        ((off >> (SRAM_ADDR_W + 1)) != '0);
`else
  assign out_of_range = 1'b0;
`endif

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and SRAM pin decode from the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ce_n       = 1'b1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    dq_oe      = 1'b0;
    dq_out     = '0;
    phase_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = '0;
          state_d = out_of_range ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW: begin
        if (last) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (last) state_d = ST_DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_LOW || state_q == ST_HIGH) begin
      ce_n       = 1'b0;
      phase_addr = {word_q, state_q == ST_HIGH};
      if (is_wr_q) begin
        dq_oe  = 1'b1;
        // we_n rises one cycle before the phase ends so data outlives the strobe
        we_n   = last;
        dq_out = (state_q == ST_HIGH) ? wdata_q[DATA_W-1:16] : wdata_q[15:0];
      end else begin
        oe_n = 1'b0;
      end
    end
  end

  // Request capture and read-data assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && req) begin
        word_q  <= off[SRAM_ADDR_W:2];
        wdata_q <= bus_if.wdata;
        is_wr_q <= bus_if.wr_en;
        if (out_of_range && !bus_if.wr_en) rdata_q <= '0;
      end
      if (state_q == ST_LOW && last && !is_wr_q) lo_q <= bus_if.sram_dq_in;
      if (state_q == ST_HIGH && last && !is_wr_q) rdata_q <= {bus_if.sram_dq_in, lo_q};
    end
  end

  assign bus_if.ready       = ~req | (state_q == ST_DONE);
  assign bus_if.rdata       = rdata_q;
  assign bus_if.sram_addr   = phase_addr;
  assign bus_if.sram_dq_out = dq_out;
  assign bus_if.sram_dq_oe  = dq_oe;
  assign bus_if.sram_ce_n   = ce_n;
  assign bus_if.sram_oe_n   = oe_n;
  assign bus_if.sram_we_n   = we_n;

endmodule

// File: tb/tb_sram_mem_initiator.sv
// Bench for sram_mem_initiator: directed table, hand-written corner sequences
// (out-of-window read, reset mid-access) and randomized traffic checked
// against a word-level reference memory.
module tb_sram_mem_initiator;
  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk;
  logic rst;

  sram_mem_initiator_if #(.ADDR_W(32), .DATA_W(32), .SRAM_ADDR_W(18)) bus_if ();

  sram_mem_initiator #(
    .ADDR_W(32), .DATA_W(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(W), .BASE_ADDR(BASE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // SRAM pin model: writes on a low we_n sampled mid-cycle, asynchronous read.
  logic [15:0] sram_mem [0:(1<<18)-1];

  function automatic logic [15:0] init_hw(input logic [17:0] h);
    return h[15:0] ^ 16'hA5A5;
  endfunction

  initial begin
    for (int i = 0; i < (1 << 18); i++) sram_mem[i] = init_hw(18'(i));
  end

  always @(negedge clk) begin
    if (bus_if.sram_ce_n === 1'b0 && bus_if.sram_we_n === 1'b0 && bus_if.sram_dq_oe === 1'b1)
      sram_mem[bus_if.sram_addr] <= bus_if.sram_dq_out;
  end

  assign bus_if.sram_dq_in = (bus_if.sram_ce_n === 1'b0 && bus_if.sram_oe_n === 1'b0)
                             ? sram_mem[bus_if.sram_addr] : 16'h0000;

  // Reference model: word-addressed memory, last completed load word.
  logic [31:0] ref_words [int unsigned];
  logic [31:0] cur_rdata;

  task automatic ref_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [17:0] hw,
                            output logic [31:0] rd_exp, output bit oor);
    logic [31:0] off;
    int unsigned wi;
    off = addr - BASE;
    wi  = (off / 4) % (1 << 17);
    hw  = 18'(wi * 2);
`ifdef SRAM_RANGE_CHECK_EN
    oor = (addr < BASE) || (off >= 32'h0008_0000);
`else
    oor = 1'b0;
`endif
    if (wr) begin
      if (!oor) ref_words[wi] = wdata;
    end else if (rd) begin
      if (oor)                         cur_rdata = 32'h0;
      else if (ref_words.exists(wi))   cur_rdata = ref_words[wi];
      else cur_rdata = {init_hw(18'(wi * 2 + 1)), init_hw(18'(wi * 2))};
    end
    rd_exp = cur_rdata;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit pins_idle();
    return bus_if.sram_ce_n === 1'b1 && bus_if.sram_oe_n === 1'b1 &&
           bus_if.sram_we_n === 1'b1 && bus_if.sram_dq_oe === 1'b0;
  endfunction

  // Expected pin state in SRAM cycle c (1..2W) of an access.
  function automatic bit pins_phase_ok(input int c, input bit wr, input logic [31:0] wdata,
                                       input logic [17:0] hw);
    bit hi;
    int k;
    bit ok;
    hi = (c > W);
    k  = (c - 1) % W;
    ok = (bus_if.sram_ce_n === 1'b0) && (bus_if.sram_addr === hw + 18'(hi));
    if (wr)
      ok = ok && bus_if.sram_dq_oe === 1'b1 && bus_if.sram_oe_n === 1'b1 &&
           bus_if.sram_we_n === (k == W - 1) &&
           bus_if.sram_dq_out === (hi ? wdata[31:16] : wdata[15:0]);
    else
      ok = ok && bus_if.sram_dq_oe === 1'b0 && bus_if.sram_oe_n === 1'b0 &&
           bus_if.sram_we_n === 1'b1;
    return ok;
  endfunction

  // One full access, request applied right after a rising edge (cycle 0).
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [17:0] exp_hw, input logic [31:0] exp_rdata,
                        input bit oor);
    int cyc;
    int exp_len;
    int pin_err;
    @(posedge clk); #1;
    bus_if.rd_en   = rd;
    bus_if.wr_en   = wr;
    bus_if.address = addr;
    bus_if.wdata   = wdata;
    @(negedge clk);
    pin_err = 0;
    exp_len = oor ? 1 : 2 * W + 1;
    if (bus_if.ready !== 1'b0 || !pins_idle()) pin_err++;
    cyc = 0;
    while (bus_if.ready !== 1'b1 && cyc < 4 * W + 8) begin
      @(negedge clk);
      cyc++;
      if (cyc < exp_len) begin
        if (!pins_phase_ok(cyc, wr, wdata, exp_hw)) pin_err++;
      end else if (cyc == exp_len) begin
        if (!pins_idle()) pin_err++;
      end
    end
    chk({tag, "_stall"}, 64'(cyc), 64'(exp_len));
    chk({tag, "_pins"}, 64'(pin_err), 64'd0);
    chk({tag, "_rdata"}, 64'(bus_if.rdata), 64'(exp_rdata));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus_if.rd_en = 1'b0;
      bus_if.wr_en = 1'b0;
      @(negedge clk);
      chk("idle", {62'd0, bus_if.ready, pins_idle()}, 64'd3);
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_hw;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [17:0] hw;
    logic [31:0] rexp;
    bit          oor;
    bit          rd, wr;
    logic [31:0] addr, wdata;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'd0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 18'd6, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1037, 32'h0,        18'd6, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 32'd1030, 32'h0,        18'd2, 32'h12345678};

    rst = 1'b1;
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.address = '0;
    bus_if.wdata = '0;
    cur_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(bus_if.ready), 64'd1);
    chk("rst_rdata", 64'(bus_if.rdata), 64'd0);
    chk("rst_addr", 64'(bus_if.sram_addr), 64'd0);
    chk("rst_dq_out", 64'(bus_if.sram_dq_out), 64'd0);
    chk("rst_pins", 64'(pins_idle()), 64'd1);

    // Directed table, applied back to back with the request held across DONE.
    for (int i = 0; i < 6; i++) begin
      ref_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, hw, rexp, oor);
      access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_hw, vecs[i].exp_rdata, 1'b0);
    end
    chk("sram_lo0", 64'(sram_mem[0]), 64'hBEEF);
    chk("sram_hi1", 64'(sram_mem[1]), 64'hDEAD);
    idle_cycles(1);

    // Read below the SRAM window.
    ref_access(1'b1, 1'b0, 32'd512, 32'h0, hw, rexp, oor);
`ifdef SRAM_RANGE_CHECK_EN
    access("below_base", 1'b1, 1'b0, 32'd512, 32'h0, 18'd0, 32'h0, 1'b1);
`else
    chk("wrap_hw", 64'(hw), 64'h3FF00);
    access("below_base", 1'b1, 1'b0, 32'd512, 32'h0, 18'h3FF00, rexp, 1'b0);
`endif
    idle_cycles(2);

    // Reset asserted in the second HIGH cycle of a write.
    @(posedge clk); #1;
    bus_if.rd_en   = 1'b0;
    bus_if.wr_en   = 1'b1;
    bus_if.address = BASE + 32'h2000;
    bus_if.wdata   = 32'hA1B2C3D4;
    repeat (W + 3) @(negedge clk);
    chk("pre_rst_we", 64'({bus_if.sram_ce_n, bus_if.sram_we_n}), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_pins", 64'(pins_idle()), 64'd1);
    chk("midrst_rdata", 64'(bus_if.rdata), 64'd0);
    chk("midrst_ready", 64'(bus_if.ready), 64'd0);
    @(posedge clk); #1;
    bus_if.wr_en = 1'b0;
    rst = 1'b0;
    cur_rdata = 32'h0;
    idle_cycles(1);

    // Randomized traffic with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind  = $urandom_range(0, 2);
      rd    = (kind != 1);
      wr    = (kind != 0);
      addr  = BASE + $urandom_range(0, 1023);
`ifdef SRAM_RANGE_CHECK_EN
      if ($urandom_range(0, 7) == 0) addr = $urandom_range(0, 1023);
`endif
      wdata = $urandom;
      ref_access(rd, wr, addr, wdata, hw, rexp, oor);
      access($sformatf("rnd%0d", n), rd, wr, addr, wdata, hw, rexp, oor);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
